// File: rtl/enc_cavlc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : enc_cavlc_pkg
// Description : Shared definitions for the CAVLC level-encoding path:
//               encoder phase codes, level width, coefficient limit,
//               scheduler control FSM states and latch-time clamp helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package enc_cavlc_pkg;

    localparam int RES_WIDTH = 16;
    localparam int MAX_COEFF = 16;

    // Encoder phase codes driven on the scheduler's state output.
    localparam logic [3:0] ENC_INIT   = 4'd0;
    localparam logic [3:0] ENC_CYCLE0 = 4'd1;
    localparam logic [3:0] ENC_CYCLE1 = 4'd2;
    localparam logic [3:0] ENC_CYCLE2 = 4'd3;
    localparam logic [3:0] ENC_CYCLE3 = 4'd4;
    localparam logic [3:0] ENC_CYCLE4 = 4'd5;
    localparam logic [3:0] ENC_CYCLE5 = 4'd6;
    localparam logic [3:0] ENC_CYCLE6 = 4'd7;
    localparam logic [3:0] ENC_CYCLE7 = 4'd8;

    typedef enum logic [1:0] {
        CTL_IDLE = 2'd0,
        CTL_PRE  = 2'd1,
        CTL_RUN  = 2'd2,
        CTL_FIN  = 2'd3
    } ctl_state_t;

    // Saturate the requested coefficient count at the block maximum.
    function automatic logic [4:0] clamp_n(input logic [4:0] tc, input logic [4:0] max_n);
        return (tc > max_n) ? max_n : tc;
    endfunction

    // Trailing ones can never exceed the (already clamped) coefficient count.
    function automatic logic [1:0] clamp_t1(input logic [1:0] t1, input logic [4:0] n);
        return ({3'b000, t1} > n) ? 2'(n) : t1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cavlc_level_sched_if.sv
`default_nettype none
// ============================================================================
// Module      : cavlc_level_sched_if
// Description : Bundle between the CAVLC level scheduler, the packer/control
//               side (start, flush, block counts), the coefficient buffer
//               (addresses, read data) and the level encoder (state, enc_en,
//               level pair, latched counts, busy/done).
//               slave  : the scheduler.
//               master : the surrounding CAVLC logic / testbench.
// Revision    : 1.0 - initial release
// ============================================================================
interface cavlc_level_sched_if #(
    parameter int LEVEL_W = enc_cavlc_pkg::RES_WIDTH
);
    logic               start;
    logic               flush;
    logic [4:0]         totalcoeff_i;
    logic [1:0]         trailones_i;
    logic [3:0]         rd_addr0;
    logic [3:0]         rd_addr1;
    logic [LEVEL_W-1:0] rd_data0;
    logic [LEVEL_W-1:0] rd_data1;
    logic [3:0]         state;
    logic               enc_en;
    logic [LEVEL_W-1:0] level0;
    logic [LEVEL_W-1:0] level1;
    logic [4:0]         totalcoeff_o;
    logic [1:0]         trailones_o;
    logic               busy;
    logic               done;

    modport slave (
        input  start, flush, totalcoeff_i, trailones_i, rd_data0, rd_data1,
        output rd_addr0, rd_addr1, state, enc_en, level0, level1,
               totalcoeff_o, trailones_o, busy, done
    );

    modport master (
        output start, flush, totalcoeff_i, trailones_i, rd_data0, rd_data1,
        input  rd_addr0, rd_addr1, state, enc_en, level0, level1,
               totalcoeff_o, trailones_o, busy, done
    );
endinterface
`default_nettype wire

// File: rtl/cavlc_level_sched.sv
`default_nettype none
// ============================================================================
// Module      : cavlc_level_sched
// Description : CAVLC level-encoding sequencer. Latches a block's coefficient
//               and trailing-ones counts on start, streams nonzero levels two
//               per cycle from the coefficient buffer to the level encoder,
//               drives the encoder phase/enable and pulses done at the end.
// Ports       : clk, rst_n (async, active-low)
//               bus (slave) : start/flush/counts in, buffer address/data,
//                             encoder state/enc_en/levels, latched counts,
//                             busy/done out.
// Revision    : 1.0 - initial release
// ============================================================================
module cavlc_level_sched #(
    parameter int LEVEL_W   = enc_cavlc_pkg::RES_WIDTH,
    parameter int MAX_COEFF = enc_cavlc_pkg::MAX_COEFF
) (
    input  wire                 clk,
    input  wire                 rst_n,
    cavlc_level_sched_if.slave  bus
);
    import enc_cavlc_pkg::*;

    localparam logic [4:0] c_max_n = 5'(MAX_COEFF);

    ctl_state_t         ctl_q;
    logic [2:0]         k_q;        // pair counter during RUN
    logic [3:0]         pidx_q;     // pair index of the addresses on the bus
    logic [4:0]         n_q;
    logic [1:0]         t1_q;
    logic [3:0]         enc_st_q;
    logic               enc_en_q;
    logic [LEVEL_W-1:0] level0_q;
    logic [LEVEL_W-1:0] level1_q;
    logic               busy_q;
    logic               done_q;

    logic [LEVEL_W-1:0] level0_d;
    logic [LEVEL_W-1:0] level1_d;
    logic [4:0]         n_lat_d;
    logic [1:0]         t1_lat_d;
    logic [2:0]         last_k;

    // Entry indices are kept 5 bits wide so that the pair after entry 15
    // (indices 16/17) compares as out of range and is masked, even though
    // the 4-bit buffer address has wrapped.
    always_comb begin
        level0_d = ({pidx_q, 1'b0} < n_q) ? bus.rd_data0 : '0;
        level1_d = ({pidx_q, 1'b1} < n_q) ? bus.rd_data1 : '0;
        n_lat_d  = clamp_n(bus.totalcoeff_i, c_max_n);
        t1_lat_d = clamp_t1(bus.trailones_i, n_lat_d);
        last_k   = 3'((n_q - 5'd1) >> 1);  // P-1, only used while n_q >= 1
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctl_q    <= CTL_IDLE;
            k_q      <= '0;
            pidx_q   <= '0;
            n_q      <= '0;
            t1_q     <= '0;
            enc_st_q <= ENC_INIT;
            enc_en_q <= 1'b0;
            level0_q <= '0;
            level1_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else if (bus.flush) begin
            ctl_q    <= CTL_IDLE;
            k_q      <= '0;
            pidx_q   <= '0;
            n_q      <= '0;
            t1_q     <= '0;
            enc_st_q <= ENC_INIT;
            enc_en_q <= 1'b0;
            level0_q <= '0;
            level1_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            case (ctl_q)
                // FIN accepts a new start just like IDLE so blocks can run
                // back to back without an idle gap.
                CTL_IDLE, CTL_FIN: begin
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                    ctl_q  <= CTL_IDLE;
                    if (bus.start) begin
                        n_q  <= n_lat_d;
                        t1_q <= t1_lat_d;
                        if (n_lat_d != 5'd0) begin
                            ctl_q  <= CTL_PRE;
                            busy_q <= 1'b1;
                        end else begin
                            ctl_q  <= CTL_FIN;
                            done_q <= 1'b1;
                        end
                    end
                end
                // Entries 0/1 are already addressed; capture them for enc
                // cycle 0 and move the address to the next pair.
                CTL_PRE: begin
                    level0_q <= level0_d;
                    level1_q <= level1_d;
                    pidx_q   <= 4'd1;
                    k_q      <= 3'd0;
                    enc_st_q <= ENC_CYCLE0;
                    enc_en_q <= 1'b1;
                    ctl_q    <= CTL_RUN;
                end
                CTL_RUN: begin
                    if (k_q == last_k) begin
                        ctl_q    <= CTL_FIN;
                        done_q   <= 1'b1;
                        busy_q   <= 1'b0;
                        enc_en_q <= 1'b0;
                        enc_st_q <= ENC_INIT;
                        level0_q <= '0;
                        level1_q <= '0;
                        pidx_q   <= '0;
                        k_q      <= '0;
                    end else begin
                        k_q      <= k_q + 3'd1;
                        pidx_q   <= pidx_q + 4'd1;
                        enc_st_q <= enc_st_q + 4'd1;
                        level0_q <= level0_d;
                        level1_q <= level1_d;
                    end
                end
                default: ctl_q <= CTL_IDLE;
            endcase
        end
    end

    assign bus.rd_addr0     = {pidx_q[2:0], 1'b0};
    assign bus.rd_addr1     = {pidx_q[2:0], 1'b1};
    assign bus.state        = enc_st_q;
    assign bus.enc_en       = enc_en_q;
    assign bus.level0       = level0_q;
    assign bus.level1       = level1_q;
    assign bus.totalcoeff_o = n_q;
    assign bus.trailones_o  = t1_q;
    assign bus.busy         = busy_q;
    assign bus.done         = done_q;

endmodule
`default_nettype wire
